// File: rtl/shift_sub_divider.sv
// shift_sub_divider
//   Sequential unsigned restoring divider. It produces one quotient bit per
//   clock using shift-and-subtract, so a division takes WIDTH cycles.
//   A divide by zero finishes on the accepting edge and flags div_by_zero.
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   rst          synchronous active-low reset (0 = reset)
//   start        request; accepted only in IDLE or DONE
//   A, B         dividend and divisor; captured on the accepting edge only
//   quotient     floor(A / B); valid while done=1
//   remainder    A mod B; valid while done=1
//   busy         high while a division is in progress
//   done         level flag; held until the next accepted start or reset
//   div_by_zero  high together with done when the captured B was 0
module shift_sub_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] dividend_q;   // shifts left; quotient bits fill from LSB
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH:0]   prem_q;       // partial remainder, one guard bit
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    // One restoring step. prem_q < divisor, so shifted < 2*divisor and the
    // trial's top bit is set exactly when the subtraction went negative.
    logic [WIDTH:0]   shifted_d;
    logic [WIDTH:0]   trial_d;
    logic             qbit_d;
    logic [WIDTH:0]   prem_d;
    logic [WIDTH-1:0] dividend_d;

    assign shifted_d  = {prem_q[WIDTH-1:0], dividend_q[WIDTH-1]};
    assign trial_d    = shifted_d - {1'b0, divisor_q};
    assign qbit_d     = ~trial_d[WIDTH];
    assign prem_d     = qbit_d ? trial_d : shifted_d;
    assign dividend_d = {dividend_q[WIDTH-2:0], qbit_d};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            dividend_q  <= '0;
            divisor_q   <= '0;
            prem_q      <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (B != '0) begin
                            dividend_q <= A;
                            divisor_q  <= B;
                            prem_q     <= '0;
                            cnt_q      <= '0;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                            dbz_q      <= 1'b0;
                            state_q    <= S_CALC;
                        end else begin
                            // No iteration needed: report saturated quotient.
                            quotient_q  <= '1;
                            remainder_q <= A;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            dbz_q       <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    dividend_q <= dividend_d;
                    prem_q     <= prem_d;
                    cnt_q      <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        // Last step: publish this step's results directly.
                        quotient_q  <= dividend_d;
                        remainder_q <= prem_d[WIDTH-1:0];
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/shift_sub_divider.md
Name: shift_sub_divider

Overview:
- Sequential unsigned restoring divider. It is the inverse companion of the shift-add multiplier and uses the same clocked-operand / done-flag style.
- Computes quotient and remainder of A / B one bit per clock, using shift-and-subtract.
- Used in the arithmetic datapath wherever the multiplier's products must be scaled back down.

Parameters:
- WIDTH, 8, bit width of dividend, divisor, quotient and remainder (must be >= 2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset. Sampled on rising edge of clk; 0 = reset.
- start  input  1  request; sampled on rising edge; accepted only in IDLE or DONE.
- A  input  WIDTH  dividend; captured on the accepting edge only.
- B  input  WIDTH  divisor; captured on the accepting edge only.
- quotient  output  WIDTH  A / B (floor); valid while done=1.
- remainder  output  WIDTH  A mod B; valid while done=1.
- busy  output  1  high while in CALC.
- done  output  1  level flag; high in DONE until next accepted start or reset.
- div_by_zero  output  1  high with done when captured B was 0.

Behaviour:
- Reset (rst=0 at a rising edge), from any state including mid-CALC:
  - state = IDLE.
  - quotient, remainder, busy, done, div_by_zero, step counter and internal registers all = 0.
  - start is ignored on that edge.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and B!=0 → capture A into dividend shift register, B into divisor register.
  - Clear partial remainder (WIDTH+1 bits) and counter; go to CALC; busy=1.
  - start=1 and B==0 → go to DONE in one edge with quotient = all ones, remainder = A, div_by_zero=1, done=1.
- CALC: one restoring step per edge.
  - Trial = {partial_rem[WIDTH-1:0], dividend_msb} - {0, divisor}, computed at WIDTH+1 bits.
  - Trial non-negative → partial_rem = trial, quotient bit = 1.
  - Otherwise partial_rem = the shifted value, quotient bit = 0.
  - Dividend register shifts left and the quotient bit enters at the LSB; counter increments.
  - After WIDTH steps: the same edge that performs the last step loads quotient/remainder outputs, sets done=1, busy=0, and moves to DONE.
- Latency: with start accepted at edge N, done is first high after edge N+WIDTH (8 cycles for WIDTH=8). Divide-by-zero: after edge N+1... no: after edge N (the accepting edge itself sets DONE).
- start during CALC is ignored: no recapture, and latency is unaffected. A and B may change freely during CALC.
- DONE:
  - Outputs are held stable and done stays high.
  - start=1 is accepted exactly as in IDLE. On that edge done and div_by_zero clear (or reassert immediately for B==0), busy=1.
- Outputs are only registered. quotient and remainder may hold stale values outside DONE; they are cleared only by reset.
- Invariant whenever done=1 and div_by_zero=0: quotient*B + remainder == A and remainder < B.
- Boundaries:
  - A < B → quotient 0, remainder A.
  - B=1 → quotient A, remainder 0.
  - A=B → 1, 0.
  - A=0 → 0, 0 (B!=0).

Test Plan:
- Reset then start with A=100, B=7 → after 8 cycles done=1, quotient=14, remainder=2, busy=0, div_by_zero=0; done stays high with no start.
- Back-to-back cases restarted from DONE: 255/1 → 255 r0; 7/100 → 0 r7; 255/255 → 1 r0; 0/5 → 0 r0; 128/2 → 64 r0; 170/13 → 13 r1. Each must have done low one cycle after the new start and high again exactly 8 cycles after it.
- A=200, B=0 with start → done and div_by_zero high one cycle later, quotient=255, remainder=200. A following start with 200/3 → div_by_zero low, result 66 r2.
- Start 250/7; pulse start with A=9, B=3 on cycle 3 of CALC and change A/B → result 35 r5 at the original cycle-8 timing.
- Start 250/7; assert rst=0 on cycle 4 of CALC → the next cycle shows busy=0, done=0, quotient=0, remainder=0. After rst=1, start 60/6 → 10 r0 after 8 cycles.
- Randomised sweep of 500 (A, B≠0) pairs → quotient*B + remainder == A and remainder < B on every done.
